uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte-stream sources, such as the register hex viewer, a command echo and a status reporter.
- Each source raises a request for a whole packet. The arbiter grants one source round-robin and locks the grant until that source drops its request, so packets never interleave.
- It forwards the granted source's byte strobes to the UART transmitter and returns a per-source busy signal that each source uses as its tx-busy input.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ packet sources.
// Define ARB_TIMEOUT_EN to enable the idle-lock timeout; by default locks last until i_req drops.
//
// state  | meaning
// IDLE   | no grant, waiting for an eligible request with the transmitter idle
// LOCKED | grant held by source r_ptr, its byte strobes are forwarded
// DRAIN  | grant released, waiting for the last byte to leave the transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_send_byte,
    input  logic [8*NUM_REQ-1:0]   i_byte,
    input  logic                   i_tx_busy,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [NUM_REQ-1:0]     o_busy,
    output logic                   o_tx_send,
    output logic [7:0]             o_tx_byte,
    output logic                   o_active,
    output logic                   o_timeout
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOCKED = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    logic [1:0]          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [PW-1:0]       r_ptr;
    logic                r_tx_send;
    logic [7:0]          r_tx_byte;
    logic                r_pend;
    logic                r_timeout;

    logic                w_line_busy;
    logic [NUM_REQ-1:0]  w_elig;
    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_idx;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic                w_req_g;
    logic [7:0]          w_byte_g;
    logic                w_fire;
    logic                w_revoke;

    // pend bridges the gap between our strobe and the transmitter raising busy
    assign w_line_busy = i_tx_busy | r_tx_send | r_pend;
    assign o_busy      = ~r_grant | {NUM_REQ{w_line_busy}};
    assign w_req_g     = i_req[r_ptr];
    assign w_byte_g    = i_byte[int'(r_ptr)*8 +: 8];
    assign w_fire      = (r_state == S_LOCKED) & i_send_byte[r_ptr] & ~w_line_busy;
    assign w_win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_mask;

    assign w_revoke = (r_state == S_LOCKED) && w_req_g && !w_fire &&
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_elig   = i_req & ~r_mask;

    // A revoked source stays masked until it lets go of its request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_mask <= '0;
        end else begin
            if (r_state != S_LOCKED || w_fire)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            r_mask <= (r_mask | (w_revoke ? r_grant : '0)) & i_req;
        end
    end
`else
    assign w_revoke = 1'b0;
    assign w_elig   = i_req;
`endif

    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_ptr     <= PW'(NUM_REQ - 1);
            r_tx_send <= 1'b0;
            r_tx_byte <= 8'h00;
            r_pend    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_tx_send <= w_fire;
            r_timeout <= w_revoke;
            if (w_fire)
                r_tx_byte <= w_byte_g;
            if (r_tx_send)
                r_pend <= 1'b1;
            else if (i_tx_busy)
                r_pend <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_found && !i_tx_busy) begin
                        r_grant <= w_win_oh;
                        r_ptr   <= w_win;
                        r_state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (!w_req_g || w_revoke) begin
                        r_grant <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!w_line_busy)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_tx_send = r_tx_send;
    assign o_tx_byte = r_tx_byte;
    assign o_active  = (r_state != S_IDLE);
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run against a packet-level model.
// The timeout scenario and model rules are included when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   send = '0;
    logic [8*N-1:0] bytes = '0;
    logic           tx_busy;
    logic [N-1:0]   grant, busy;
    logic           tx_send, active, timeout;
    logic [7:0]     tx_byte;

    int errors = 0;
    int checks = 0;
    int tx_cnt = 0;
    int tx_len = 10;
    int n_pulses = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_send_byte(send), .i_byte(bytes),
        .i_tx_busy(tx_busy), .o_grant(grant), .o_busy(busy), .o_tx_send(tx_send),
        .o_tx_byte(tx_byte), .o_active(active), .o_timeout(timeout)
    );

    // Transmitter: busy for tx_len cycles after it sees a strobe; unaffected by arbiter reset
    always @(posedge clk) begin
        if (tx_send) tx_cnt <= tx_len;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0);

    always @(negedge clk) if (tx_send === 1'b1) n_pulses++;

    // Packet-level reference: who owns the line, whether a byte is in flight, who was served last
    int         m_phase;   // 0 free, 1 owned, 2 waiting for line to empty
    int         m_owner, m_last, m_cnt;
    logic       m_send, m_pend, m_timeout;
    logic [7:0] m_byte;
    bit         m_revoked [N];

    function automatic logic m_busy(int k);
        return !(m_phase == 1 && m_owner == k) || tx_busy || m_send || m_pend;
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_phase == 1) g[m_owner] = 1'b1;
        return g;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_owner <= 0; m_last <= N - 1; m_cnt <= 0;
            m_send <= 0; m_pend <= 0; m_timeout <= 0; m_byte <= 8'h00;
            for (int k = 0; k < N; k++) m_revoked[k] <= 0;
        end else begin
            bit fwd;
            int w;
            fwd = 0;
            w = -1;
            m_send <= 0;
            m_timeout <= 0;
            if (m_send) m_pend <= 1;
            else if (tx_busy) m_pend <= 0;
            for (int k = 0; k < N; k++) if (!req[k]) m_revoked[k] <= 0;
            if (m_phase == 0) begin
                if (!tx_busy)
                    for (int s = 1; s <= N; s++)
                        if (w < 0 && req[(m_last + s) % N] && !m_revoked[(m_last + s) % N])
                            w = (m_last + s) % N;
                if (w >= 0) begin
                    m_owner <= w; m_last <= w; m_phase <= 1; m_cnt <= 0;
                end
            end else if (m_phase == 1) begin
                fwd = send[m_owner] && !m_busy(m_owner);
                if (fwd) begin
                    m_send <= 1;
                    m_byte <= bytes[8*m_owner +: 8];
                end
                m_cnt <= fwd ? 0 : m_cnt + 1;
                if (!req[m_owner]) m_phase <= 2;
`ifdef ARB_TIMEOUT_EN
                else if (!fwd && m_cnt == TO - 1) begin
                    m_phase <= 2; m_timeout <= 1; m_revoked[m_owner] <= 1;
                end
`endif
            end else if (!tx_busy && !m_send && !m_pend) begin
                m_phase <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1; req = '0; send = '0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req = '0; send = '0; bytes = '0;
        tick();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send: got %b expected 0", tx_send); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 3'b111) begin errors++; $display("FAIL reset_busy: got %b expected 111", busy); end
        rst = 0;
    endtask

    task automatic test_single_source();
        logic [7:0] msg [9];
        int  p0;
        bit  other_ok;
        msg = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0a};
        tx_len = 10;
        other_ok = 1;
        p0 = n_pulses;
        req = 3'b001;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", grant); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", active); end
        for (int b = 0; b < 9; b++) begin
            int w;
            w = 0;
            while (busy[0] && w < 100) begin
                if (busy[2:1] !== 2'b11) other_ok = 0;
                tick();
                w++;
            end
            checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_wait_idle: got busy %b expected 0", busy[0]); end
            send = 3'b001; bytes[7:0] = msg[b];
            tick();
            send = '0;
            if (busy[2:1] !== 2'b11) other_ok = 0;
            checks++; if (tx_send !== 1'b1 || tx_byte !== msg[b])
                begin errors++; $display("FAIL single_byte%0d: got send=%b byte=%h expected send=1 byte=%h", b, tx_send, tx_byte, msg[b]); end
            tick();
            checks++; if (tx_send !== 1'b0) begin errors++; $display("FAIL single_one_cycle%0d: got %b expected 0", b, tx_send); end
        end
        checks++; if (!other_ok) begin errors++; $display("FAIL single_other_busy: got a low o_busy[2:1] expected 11"); end
        req = '0;
        for (int w = 0; w < 100 && active; w++) tick();
        checks++; if (n_pulses - p0 !== 9) begin errors++; $display("FAIL single_pulse_count: got %0d expected 9", n_pulses - p0); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_release: got active %b expected 0", active); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 3'b101;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rr_first: got %b expected 001", grant); end
        tick();
        req = 3'b100;
        tick();
        checks++; if (grant !== 3'b000 || active !== 1'b1) begin errors++; $display("FAIL rr_drain: got grant=%b active=%b expected 000/1", grant, active); end
        tick();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rr_idle: got active %b expected 0", active); end
        tick();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rr_second: got %b expected 100", grant); end
        req = '0;
        tick();
        tick();
        req = 3'b111;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rr_wrap: got %b expected 001", grant); end
    endtask

    task automatic test_ungranted_strobe();
        send = 3'b010; bytes[15:8] = 8'h55;
        tick();
        checks++; if (tx_send !== 1'b0 || tx_byte !== 8'h00)
            begin errors++; $display("FAIL ungranted_ignored: got send=%b byte=%h expected 0/00", tx_send, tx_byte); end
        send = 3'b011; bytes[7:0] = 8'h33;
        tick();
        checks++; if (tx_send !== 1'b1 || tx_byte !== 8'h33)
            begin errors++; $display("FAIL granted_wins: got send=%b byte=%h expected 1/33", tx_send, tx_byte); end
        send = 3'b001; bytes[7:0] = 8'h77;
        tick();
        send = '0;
        checks++; if (tx_send !== 1'b0 || tx_byte !== 8'h33)
            begin errors++; $display("FAIL violation_dropped: got send=%b byte=%h expected 0/33", tx_send, tx_byte); end
        req = '0;
        for (int w = 0; w < 100 && active; w++) tick();
    endtask

    task automatic test_last_byte_drop();
        bit ok;
        logic prev_busy;
        apply_reset();
        tx_len = 10;
        req = 3'b011;
        tick();
        send = 3'b001; bytes[7:0] = 8'h0a; req = 3'b010;
        tick();
        send = '0;
        checks++; if (tx_send !== 1'b1 || tx_byte !== 8'h0a || grant !== 3'b000)
            begin errors++; $display("FAIL last_byte: got send=%b byte=%h grant=%b expected 1/0a/000", tx_send, tx_byte, grant); end
        ok = 1;
        prev_busy = 1;
        for (int w = 0; w < 60 && grant === 3'b000; w++) begin
            prev_busy = tx_busy;
            tick();
            if (grant !== 3'b000 && prev_busy) ok = 0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL no_grant_while_busy: got a grant after busy cycle expected none"); end
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL last_regrant: got %b expected 010", grant); end
    endtask

    task automatic test_reset_mid_packet();
        for (int w = 0; w < 100 && busy[1]; w++) tick();
        send = 3'b010; bytes[15:8] = 8'ha5;
        tick();
        send = '0;
        checks++; if (tx_send !== 1'b1) begin errors++; $display("FAIL midrst_pre: got send %b expected 1", tx_send); end
        rst = 1;
        #1;
        checks++; if (tx_send !== 1'b0 || grant !== 3'b000 || active !== 1'b0)
            begin errors++; $display("FAIL midrst_async: got send=%b grant=%b active=%b expected 0/000/0", tx_send, grant, active); end
        tick();
        rst = 0; req = 3'b010;
        tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL midrst_regrant: got %b expected 010", grant); end
        req = '0;
        for (int w = 0; w < 100 && active; w++) tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        apply_reset();
        req = 3'b011;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL to_grant: got %b expected 001", grant); end
        ok = 1;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (timeout !== 1'b0 || grant !== 3'b001) ok = 0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL to_early: got early timeout or lost grant expected hold 15 cycles"); end
        tick();
        checks++; if (timeout !== 1'b1 || grant !== 3'b000)
            begin errors++; $display("FAIL to_pulse: got timeout=%b grant=%b expected 1/000", timeout, grant); end
        tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", timeout); end
        for (int w = 0; w < 10 && grant === 3'b000; w++) tick();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL to_next: got %b expected 010", grant); end
        req = 3'b001;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant !== 3'b000) ok = 0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL to_masked: got grant to revoked source expected none"); end
        req = 3'b000;
        tick();
        req = 3'b001;
        tick();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL to_unmask: got %b expected 001", grant); end
        req = '0;
        for (int w = 0; w < 100 && active; w++) tick();
    endtask
`endif

    task automatic test_random();
        int bad;
        bad = 0;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            checks++;
            if (grant !== m_grant() || tx_send !== m_send || tx_byte !== m_byte ||
                active !== (m_phase != 0) || timeout !== m_timeout) begin
                errors++;
                if (bad++ < 20)
                    $display("FAIL rand_outputs c=%0d: got g=%b s=%b b=%h a=%b t=%b expected g=%b s=%b b=%h a=%b t=%b",
                             c, grant, tx_send, tx_byte, active, timeout,
                             m_grant(), m_send, m_byte, m_phase != 0, m_timeout);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (busy[k] !== m_busy(k)) begin
                    errors++;
                    if (bad++ < 20) $display("FAIL rand_busy%0d c=%0d: got %b expected %b", k, c, busy[k], m_busy(k));
                end
            end
            tx_len = $urandom_range(1, 6);
            for (int k = 0; k < N; k++) begin
                if (!req[k]) begin
                    if ($urandom_range(7) == 0) req[k] = 1;
                end else if (grant[k]) begin
                    if ($urandom_range(9) == 0) req[k] = 0;
                end else if ($urandom_range(63) == 0) begin
                    req[k] = 0;
                end
                if (grant[k] && !busy[k]) send[k] = 1'($urandom_range(1));
                else send[k] = ($urandom_range(11) == 0);
                bytes[8*k +: 8] = 8'($urandom_range(255));
            end
            tick();
        end
        req = '0; send = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_ungranted_strobe();
        test_last_byte_drop();
        test_reset_mid_packet();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
